// File: rtl/int_dsp_tx_scheduler.sv
// Periodic TX frame scheduler for the FPGA-to-DSP link-layer interrupt path.
// Ports: clk; rst (async, active-low); en, tx_flag, dsp_ack, clr_ovr (inputs);
//        tx_begin, busy, overrun, ovr_cnt[7:0], frame_cnt[15:0] (all registered).
module int_dsp_tx_scheduler #(
    parameter int PERIOD = 1562500,
    parameter int CNT_W  = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        tx_flag,
    input  logic        dsp_ack,
    input  logic        clr_ovr,
    output logic        tx_begin,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  ovr_cnt,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_ACK
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             fire;
    logic             miss;

    // tick is gated by en so a disable always wins over a pending boundary
    assign tick = en && (state != IDLE) && (cnt == LAST);

    // A pending ack is consumed before the tick is evaluated
    assign fire = tick && tx_flag &&
                  ((state == RUN) || ((state == WAIT_ACK) && dsp_ack));
    assign miss = tick && (state == WAIT_ACK) && !dsp_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || state == IDLE || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tx_begin  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            ovr_cnt   <= 8'd0;
            frame_cnt <= 16'd0;
        end else begin
            tx_begin <= fire;

            if (fire) begin
                frame_cnt <= frame_cnt + 16'd1;
            end

            // A new overrun beats a coincident clear
            if (miss) begin
                overrun <= 1'b1;
                if (clr_ovr) begin
                    ovr_cnt <= 8'd1;
                end else if (ovr_cnt != 8'hFF) begin
                    ovr_cnt <= ovr_cnt + 8'd1;
                end
            end else if (clr_ovr) begin
                overrun <= 1'b0;
                ovr_cnt <= 8'd0;
            end

            if (!en) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                    RUN: begin
                        if (fire) begin
                            state <= WAIT_ACK;
                            busy  <= 1'b1;
                        end
                    end
                    WAIT_ACK: begin
                        if (dsp_ack && !fire) begin
                            state <= RUN;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
